// File: rtl/vector_pair_multiply_stream.sv
// vector_pair_multiply_stream
// Holds two LENGTH-element operand vectors A and B and, on start, streams the
// elementwise products A[i]*B[i] as one contiguous valid burst followed by a
// forced idle cycle, feeding the stream accumulator of the dot-product path.
// Optional build macro: PRODUCT_SATURATE_EN (saturate products instead of
// truncating them modulo 2^BITS).
module vector_pair_multiply_stream #(
  parameter int BITS   = 8,
  parameter int LENGTH = 10,
  localparam int IW    = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [IW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            start,
  output logic            busy,
  output logic            out_valid,
  output logic [BITS-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP
  } state_t;

  // LENGTH always fits in IW+1 bits, so the range check never truncates.
  localparam logic [IW:0]   LEN_W = (IW + 1)'(LENGTH);
  localparam logic [IW-1:0] LAST  = IW'(LENGTH - 1);

  state_t              state;
  logic [IW-1:0]       idx;
  logic [BITS-1:0]     mem_a [LENGTH];
  logic [BITS-1:0]     mem_b [LENGTH];
  logic                wr_ok;
  logic [2*BITS-1:0]   prod;
  logic [BITS-1:0]     prod_f;

  // Writes land only while idle and in range, keeping operands stable during a burst.
  assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < LEN_W);

  // Operand storage; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) begin
        mem_b[wr_addr] <= wr_data;
      end else begin
        mem_a[wr_addr] <= wr_data;
      end
    end
  end

  // Full-width unsigned product of the current element pair, reduced to BITS.
  always_comb begin
    prod = {{BITS{1'b0}}, mem_a[idx]} * {{BITS{1'b0}}, mem_b[idx]};
`ifdef PRODUCT_SATURATE_EN
    prod_f = (|prod[2*BITS-1:BITS]) ? '1 : prod[BITS-1:0];
`else
    prod_f = prod[BITS-1:0];
`endif
  end

  // Burst sequencer with registered busy/valid/data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_data  <= '0;
          if (start) begin
            state <= STREAM;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          out_valid <= 1'b1;
          out_data  <= prod_f;
          if (idx == LAST) begin
            state <= GAP;
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        GAP: begin
          out_valid <= 1'b0;
          out_data  <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_pair_multiply_stream.sv
// Self-checking bench for vector_pair_multiply_stream (BITS=8, LENGTH=4 main
// instance, plus a LENGTH=5 instance for out-of-range address handling).
module tb_vector_pair_multiply_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       out_valid;
  logic [7:0] out_data;

  logic       f_wr_en = 1'b0;
  logic       f_wr_sel = 1'b0;
  logic [2:0] f_wr_addr = '0;
  logic [7:0] f_wr_data = '0;
  logic       f_start = 1'b0;
  logic       f_busy;
  logic       f_valid;
  logic [7:0] f_data;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  acc = '0;
  logic [7:0]  ma [4];
  logic [7:0]  mb [4];
  logic [7:0]  fa [5];
  logic [7:0]  fb [5];

  vector_pair_multiply_stream #(.BITS(8), .LENGTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .out_valid(out_valid), .out_data(out_data)
  );

  vector_pair_multiply_stream #(.BITS(8), .LENGTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_sel(f_wr_sel), .wr_addr(f_wr_addr),
    .wr_data(f_wr_data), .start(f_start), .busy(f_busy), .out_valid(f_valid), .out_data(f_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fprod(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
`ifdef PRODUCT_SATURATE_EN
    return (p > 16'd255) ? 8'd255 : p[7:0];
`else
    return p[7:0];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every valid product must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_valid observed=%0d expected=none", out_data);
      end
      if (exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        acc = acc + out_data;
        checks++;
        assert (out_data === e) else begin
          errors++;
          $error("FAIL product observed=%0d expected=%0d", out_data, e);
        end
      end
    end
  end

  task automatic push_burst();
    for (int i = 0; i < 4; i++) exp_q.push_back(fprod(ma[i], mb[i]));
  endtask

  task automatic wr(input logic sel, input logic [1:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    if (sel) mb[addr] = data; else ma[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wr5(input logic sel, input logic [2:0] addr, input logic [7:0] data);
    f_wr_en = 1'b1; f_wr_sel = sel; f_wr_addr = addr; f_wr_data = data;
    if (addr < 3'd5) begin
      if (sel) fb[addr] = data; else fa[addr] = data;
    end
    @(negedge clk);
    f_wr_en = 1'b0;
  endtask

  // One start pulse and a full burst, with an optional write on the start edge
  // (must land) or on the first STREAM edge (must be dropped).
  task automatic run_burst(input string tag, input bit same_wr, input bit mid_wr,
                           input logic [1:0] waddr, input logic [7:0] wdata);
    start = 1'b1;
    if (same_wr) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = waddr; wr_data = wdata;
      ma[waddr] = wdata;
    end
    push_burst();
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_valid_start"}, out_valid, 0);
    if (mid_wr) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = waddr; wr_data = wdata;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      chk({tag, "_valid_burst"}, out_valid, 1);
      chk({tag, "_busy_burst"}, busy, 1);
    end
    @(negedge clk);
    chk({tag, "_valid_gap"}, out_valid, 0);
    chk({tag, "_data_gap"}, out_data, 0);
    chk({tag, "_busy_gap"}, busy, 0);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst and downstream sum.
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 2'(i), 8'(i + 1));
      wr(1'b1, 2'(i), 8'(i + 5));
    end
    acc = '0;
    run_burst("basic", 1'b0, 1'b0, 2'd0, 8'd0);
    chk("basic_sum", acc, 70);

    // Overflowing product: 20*20.
    wr(1'b0, 2'd0, 8'd20);
    wr(1'b1, 2'd0, 8'd20);
    for (int i = 1; i < 4; i++) wr(1'b0, 2'(i), 8'd0);
    run_burst("overflow", 1'b0, 1'b0, 2'd0, 8'd0);

    // Restore operands, then hold start high across two bursts.
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 2'(i), 8'(i + 1));
      wr(1'b1, 2'(i), 8'(i + 5));
    end
    start = 1'b1;
    push_burst();
    push_burst();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      chk("held_busy_start", busy, 1);
      chk("held_valid_start", out_valid, 0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("held_valid_burst", out_valid, 1);
      end
      if (b == 1) start = 1'b0;
      @(negedge clk);
      chk("held_valid_gap", out_valid, 0);
      chk("held_busy_gap", busy, 0);
    end
    @(negedge clk);
    chk("held_no_extra_valid", out_valid, 0);
    chk("held_no_extra_busy", busy, 0);
    chk("held_queue_drained", exp_q.size(), 0);

    // Write during STREAM is dropped; following burst is unchanged.
    run_burst("midwr", 1'b0, 1'b1, 2'd1, 8'd99);
    run_burst("after_midwr", 1'b0, 1'b0, 2'd0, 8'd0);

    // Reset after the second valid cycle.
    start = 1'b1;
    push_burst();
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_popped_two", exp_q.size(), 2);
    exp_q.delete();
    @(negedge clk);
    chk("midrst_still_idle", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_resume", out_valid, 0);
    run_burst("after_rst", 1'b0, 1'b0, 2'd0, 8'd0);

    // Write on the same edge as start lands and is used.
    run_burst("samewr", 1'b1, 1'b0, 2'd0, 8'd3);

    // LENGTH=5 instance: out-of-range addresses are dropped.
    for (int i = 0; i < 5; i++) begin
      wr5(1'b0, 3'(i), 8'(i + 1));
      wr5(1'b1, 3'(i), 8'(10 * (i + 1)));
    end
    wr5(1'b0, 3'd5, 8'd200);
    wr5(1'b1, 3'd6, 8'd200);
    wr5(1'b0, 3'd7, 8'd200);
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    chk("len5_busy_start", f_busy, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("len5_valid", f_valid, 1);
      chk("len5_product", f_data, fprod(fa[k], fb[k]));
    end
    @(negedge clk);
    chk("len5_valid_gap", f_valid, 0);
    chk("len5_busy_gap", f_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
